// File: rtl/psum_mem_arbiter_pkg.sv
// Shared types for the psum memory arbiter: FSM state encoding and the
// write-port request bundle.
package psum_mem_arbiter_pkg;

  localparam int PSUM_ADDR_W = 20;
  localparam int PSUM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_RSP     = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                   we;
    logic [PSUM_ADDR_W-1:0] addr;
    logic [PSUM_DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/psum_rdw_bypass.sv
// Read-during-write forwarding for the psum SRAM: a same-cycle read and write
// to one address returns the written word instead of the stale SRAM output.
module psum_rdw_bypass #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic              hit_q, hit_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    hit_d  = rd_en_i && wr_en_i && (rd_addr_i == wr_addr_i);
    data_d = hit_d ? wr_data_i : data_q;
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      hit_q  <= 1'b0;
      data_q <= '0;
    end else begin
      hit_q  <= hit_d;
      data_q <= data_d;
    end
  end

  assign rdata_o = hit_q ? data_q : mem_rdata_i;

endmodule

// File: rtl/psum_mem_arbiter.sv
// Shares the psum SRAM between the convolution controller (always first) and a
// host port that fills idle port cycles, with a starvation-driven one-cycle hold.
module psum_mem_arbiter
  import psum_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = PSUM_ADDR_W,
  parameter int DATA_W       = PSUM_DATA_W,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              arst_n_in,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] ctrl_write_addr,
  input  logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_re,
  input  logic [ADDR_W-1:0] ctrl_read_addr,
  output logic [DATA_W-1:0] ctrl_rdata,
  output logic              ctrl_hold,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              hold_q, hold_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic              ctrl_rd_q, ctrl_rd_d;
  logic [DATA_W-1:0] fwd_rdata;
  mem_req_t          wr_req;
  logic              in_idle, host_accept, host_blocked;

  // The host may take a port only when the controller leaves it free, or
  // unconditionally during a forced hold.
  always_comb begin
    in_idle        = (state_q == ST_IDLE);
    host_req_ready = in_idle && ((host_req_we ? !ctrl_we : !ctrl_re) || hold_q);
    host_accept    = host_req_valid && host_req_ready;
    host_blocked   = in_idle && host_req_valid && !host_req_ready;
  end

  always_comb begin
    wr_req    = '0;
    mem_re    = 1'b0;
    mem_raddr = '0;
    ctrl_rd_d = 1'b0;
    if (host_accept && host_req_we) begin
      wr_req = '{we: 1'b1, addr: host_req_addr, data: host_req_wdata};
    end else if (ctrl_we && !hold_q) begin
      wr_req = '{we: 1'b1, addr: ctrl_write_addr, data: ctrl_wdata};
    end
    if (host_accept && !host_req_we) begin
      mem_re    = 1'b1;
      mem_raddr = host_req_addr;
    end else if (ctrl_re && !hold_q) begin
      mem_re    = 1'b1;
      mem_raddr = ctrl_read_addr;
      ctrl_rd_d = 1'b1;
    end
  end

  assign mem_we    = wr_req.we;
  assign mem_waddr = wr_req.addr;
  assign mem_wdata = wr_req.data;

  // Hold lasts one cycle; the counter restarts from zero once it expires.
  always_comb begin
    hold_d     = 1'b0;
    wait_cnt_d = '0;
    if (!hold_q && host_blocked) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      hold_d     = (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1));
    end
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (host_accept && !host_req_we) state_d = ST_RD_PEND;
      end
      ST_RD_PEND: begin
        rsp_d   = fwd_rdata;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (host_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      hold_q     <= 1'b0;
      rsp_q      <= '0;
      ctrl_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hold_q     <= hold_d;
      rsp_q      <= rsp_d;
      ctrl_rd_q  <= ctrl_rd_d;
    end
  end

  psum_rdw_bypass #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bypass (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .rd_en_i     (mem_re),
    .rd_addr_i   (mem_raddr),
    .wr_en_i     (mem_we),
    .wr_addr_i   (mem_waddr),
    .wr_data_i   (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .rdata_o     (fwd_rdata)
  );

  assign ctrl_hold      = hold_q;
  assign ctrl_rdata     = ctrl_rd_q ? fwd_rdata : '0;
  assign host_rsp_valid = (state_q == ST_RSP);
  assign host_rsp_rdata = rsp_q;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter: a small registered SRAM model sits on
// the memory ports and every step checks hand-computed outputs.
module tb_psum_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          ctrl_we, ctrl_re;
  logic [AW-1:0] ctrl_write_addr, ctrl_read_addr;
  logic [DW-1:0] ctrl_wdata, ctrl_rdata;
  logic          ctrl_hold;
  logic          host_req_valid, host_req_ready, host_req_we;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          host_rsp_valid, host_rsp_ready;
  logic [DW-1:0] host_rsp_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int nChecks = 0;
  int nFails  = 0;

  logic [DW-1:0] sram [0:63];

  always #5 clk = ~clk;

  // Read-before-write SRAM: a same-address read returns the old word.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= sram[mem_raddr[5:0]];
    if (mem_we) sram[mem_waddr[5:0]] <= mem_wdata;
  end

  psum_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (16)
  ) dut (
    .clk             (clk),
    .arst_n_in       (arst_n_in),
    .ctrl_we         (ctrl_we),
    .ctrl_write_addr (ctrl_write_addr),
    .ctrl_wdata      (ctrl_wdata),
    .ctrl_re         (ctrl_re),
    .ctrl_read_addr  (ctrl_read_addr),
    .ctrl_rdata      (ctrl_rdata),
    .ctrl_hold       (ctrl_hold),
    .host_req_valid  (host_req_valid),
    .host_req_ready  (host_req_ready),
    .host_req_we     (host_req_we),
    .host_req_addr   (host_req_addr),
    .host_req_wdata  (host_req_wdata),
    .host_rsp_valid  (host_rsp_valid),
    .host_rsp_ready  (host_rsp_ready),
    .host_rsp_rdata  (host_rsp_rdata),
    .mem_we          (mem_we),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .mem_re          (mem_re),
    .mem_raddr       (mem_raddr),
    .mem_rdata       (mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge and leaves time
  // for combinational outputs to settle before the caller checks them.
  task automatic applyStimulus(
    input logic hv, input logic hwe, input logic [AW-1:0] haddr, input logic [DW-1:0] hwdata,
    input logic cwe, input logic [AW-1:0] cwaddr, input logic [DW-1:0] cwdata,
    input logic cre, input logic [AW-1:0] craddr, input logic rspRdy);
    @(negedge clk);
    host_req_valid  = hv;
    host_req_we     = hwe;
    host_req_addr   = haddr;
    host_req_wdata  = hwdata;
    ctrl_we         = cwe;
    ctrl_write_addr = cwaddr;
    ctrl_wdata      = cwdata;
    ctrl_re         = cre;
    ctrl_read_addr  = craddr;
    host_rsp_ready  = rspRdy;
    #1;
  endtask

  initial begin
    arst_n_in       = 1'b0;
    host_req_valid  = 1'b0;
    host_req_we     = 1'b0;
    host_req_addr   = '0;
    host_req_wdata  = '0;
    ctrl_we         = 1'b0;
    ctrl_write_addr = '0;
    ctrl_wdata      = '0;
    ctrl_re         = 1'b0;
    ctrl_read_addr  = '0;
    host_rsp_ready  = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_hold", ctrl_hold, 0);
    checkOutput("rst_rspv", host_rsp_valid, 0);
    checkOutput("rst_rspd", host_rsp_rdata, 0);
    checkOutput("rst_crd", ctrl_rdata, 0);
    checkOutput("rst_mwe", mem_we, 0);
    checkOutput("rst_mre", mem_re, 0);
    @(negedge clk);
    arst_n_in = 1'b1;

    // Idle controller: host write then read-back of addr 5
    applyStimulus(1, 1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    checkOutput("wr_ready", host_req_ready, 1);
    checkOutput("wr_mwe", mem_we, 1);
    checkOutput("wr_maddr", mem_waddr, 5);
    checkOutput("wr_mdata", mem_wdata, 32'hDEAD);
    checkOutput("wr_mre", mem_re, 0);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd_ready", host_req_ready, 1);
    checkOutput("rd_mre", mem_re, 1);
    checkOutput("rd_maddr", mem_raddr, 5);
    checkOutput("rd_mwe", mem_we, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pend_rspv", host_rsp_valid, 0);
    checkOutput("pend_ready", host_req_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rsp_valid", host_rsp_valid, 1);
    checkOutput("rsp_data", host_rsp_rdata, 32'hDEAD);
    checkOutput("rsp_ready", host_req_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_rspv", host_rsp_valid, 0);
    checkOutput("done_ready", host_req_ready, 1);

    // Controller read passes straight through; data one cycle later
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("crd_mre", mem_re, 1);
    checkOutput("crd_maddr", mem_raddr, 5);
    checkOutput("crd_hold", ctrl_hold, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("crd_data", ctrl_rdata, 32'hDEAD);

    // Port split: controller writes, host read takes the free read port
    applyStimulus(1, 0, 5, 0, 1, 9, 32'h99, 0, 0, 0);
    checkOutput("split_ready", host_req_ready, 1);
    checkOutput("split_mre", mem_re, 1);
    checkOutput("split_raddr", mem_raddr, 5);
    checkOutput("split_mwe", mem_we, 1);
    checkOutput("split_waddr", mem_waddr, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("split_rsp", host_rsp_rdata, 32'hDEAD);
    applyStimulus(1, 1, 6, 32'h66, 1, 9, 32'h99, 0, 0, 0);
    checkOutput("wrblk_ready", host_req_ready, 0);
    checkOutput("wrblk_waddr", mem_waddr, 9);
    checkOutput("wrblk_wdata", mem_wdata, 32'h99);

    // Starvation: continuous controller reads block a host read of addr 7
    applyStimulus(1, 1, 7, 32'h777, 0, 0, 0, 0, 0, 0);
    checkOutput("pre7_ready", host_req_ready, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 1, 20, 0);
      checkOutput("starve_ready", host_req_ready, 0);
      checkOutput("starve_hold", ctrl_hold, 0);
    end
    applyStimulus(1, 0, 7, 0, 0, 0, 0, 1, 20, 0);
    checkOutput("hold_on", ctrl_hold, 1);
    checkOutput("hold_ready", host_req_ready, 1);
    checkOutput("hold_mre", mem_re, 1);
    checkOutput("hold_raddr", mem_raddr, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 20, 0);
    checkOutput("hold_off", ctrl_hold, 0);
    checkOutput("post_raddr", mem_raddr, 20);
    checkOutput("post_rspv", host_rsp_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 20, 1);
    checkOutput("starve_rspv", host_rsp_valid, 1);
    checkOutput("starve_rspd", host_rsp_rdata, 32'h777);
    checkOutput("starve_hold2", ctrl_hold, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_done", host_rsp_valid, 0);

    // Forwarding on host path, then response backpressure
    applyStimulus(1, 0, 3, 0, 1, 3, 32'h1234, 0, 0, 0);
    checkOutput("fwd_ready", host_req_ready, 1);
    checkOutput("fwd_mre", mem_re, 1);
    checkOutput("fwd_mwe", mem_we, 1);
    applyStimulus(1, 1, 8, 32'h88, 0, 0, 0, 0, 0, 0);
    checkOutput("fwdp_ready", host_req_ready, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 8, 32'h88, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_rspv", host_rsp_valid, 1);
      checkOutput("bp_rspd", host_rsp_rdata, 32'h1234);
      checkOutput("bp_ready", host_req_ready, 0);
    end
    applyStimulus(1, 1, 8, 32'h88, 0, 0, 0, 0, 0, 1);
    checkOutput("hs_rspv", host_rsp_valid, 1);
    checkOutput("hs_ready", host_req_ready, 0);
    applyStimulus(1, 1, 8, 32'h88, 0, 0, 0, 0, 0, 0);
    checkOutput("next_ready", host_req_ready, 1);
    checkOutput("next_mwe", mem_we, 1);
    checkOutput("next_waddr", mem_waddr, 8);
    checkOutput("next_rspv", host_rsp_valid, 0);

    // Forwarding on controller path: host write hits a controller read
    applyStimulus(1, 1, 11, 32'hABCD, 0, 0, 0, 1, 11, 0);
    checkOutput("cfwd_ready", host_req_ready, 1);
    checkOutput("cfwd_mwe", mem_we, 1);
    checkOutput("cfwd_mre", mem_re, 1);
    checkOutput("cfwd_raddr", mem_raddr, 11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cfwd_data", ctrl_rdata, 32'hABCD);

    // Reset while a host read is pending
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_accept", host_req_ready, 1);
    @(negedge clk);
    host_req_valid = 1'b0;
    host_req_we    = 1'b0;
    arst_n_in      = 1'b0;
    #1;
    checkOutput("rr_rspv", host_rsp_valid, 0);
    checkOutput("rr_rspd", host_rsp_rdata, 0);
    checkOutput("rr_hold", ctrl_hold, 0);
    checkOutput("rr_crd", ctrl_rdata, 0);
    checkOutput("rr_mre", mem_re, 0);
    checkOutput("rr_mwe", mem_we, 0);
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rr_post_rspv", host_rsp_valid, 0);
    checkOutput("rr_post_ready", host_req_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rr_post_rspv2", host_rsp_valid, 0);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_new_ready", host_req_ready, 1);
    checkOutput("rr_new_mre", mem_re, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
